add_rs_bank: RTL and testbench

- Reservation-station bank for the FP adder, directly downstream of the register file.
- Allocates a tag (add_1..add_3 = 1..3) for each issued add-class instruction and drives that tag back to the register file as rs_tag. Latches the register file's op_1/op_2/tag_1/tag_2 and snoops the CDB for missing operands.
- Dispatches the oldest ready entry to the adder over a valid/ready handshake. Frees the entry when its own tag is broadcast on the CDB.

---
 rtl/add_rs_bank.sv | 129 ++++++++++++
 tb/tb_add_rs_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/add_rs_bank.sv
// add_rs_bank: FP-adder reservation-station bank with CDB snoop, age-ordered dispatch and tag-based free.
// Optional ADD_RS_PERF_CNT_EN adds saturating full-stall and dispatch counters.
module add_rs_bank #(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_BASE    = 1,
    parameter int DATA_W      = 64,
    parameter int TAG_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic [5:0]             issue_opcode,
    input  logic [DATA_W-1:0]      issue_op_1,
    input  logic [DATA_W-1:0]      issue_op_2,
    input  logic [TAG_W-1:0]       issue_tag_1,
    input  logic [TAG_W-1:0]       issue_tag_2,
    output logic [TAG_W-1:0]       rs_tag,
    output logic                   rs_full,
    input  logic [TAG_W-1:0]       cdb_id,
    input  logic [DATA_W-1:0]      cdb_data,
    output logic                   fu_valid,
    input  logic                   fu_ready,
    output logic [TAG_W-1:0]       fu_tag,
    output logic [5:0]             fu_opcode,
    output logic [DATA_W-1:0]      fu_a,
    output logic [DATA_W-1:0]      fu_b,
    output logic [NUM_ENTRIES-1:0] busy
`ifdef ADD_RS_PERF_CNT_EN
    ,
    output logic [31:0]            perf_full_cycles,
    output logic [31:0]            perf_dispatches
`endif
);
    localparam int IW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
    logic [NUM_ENTRIES-1:0] busy_q, disp_q, ready, sel;
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
    logic [5:0]             opc_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      vj_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      vk_q [NUM_ENTRIES];
    logic [TAG_W-1:0]       qj_q [NUM_ENTRIES];
    logic [TAG_W-1:0]       qk_q [NUM_ENTRIES];
    logic [IW-1:0]          alloc_idx;
    logic                   alloc, fire, byp_j, byp_k;
    assign busy    = busy_q;
    assign rs_full = &busy_q;
    assign alloc   = issue_valid & ~rs_full;
    assign fire    = fu_valid & fu_ready;
    // the register file clears its tag on this same edge, so a matching broadcast must be captured here
    assign byp_j   = issue_tag_1 != '0 && issue_tag_1 == cdb_id;
    assign byp_k   = issue_tag_2 != '0 && issue_tag_2 == cdb_id;
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!busy_q[i]) alloc_idx = IW'(i);
        rs_tag = rs_full ? '0 : TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
    end
    always_comb begin
        fu_tag    = '0;
        fu_opcode = '0;
        fu_a      = '0;
        fu_b      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            ready[i] = busy_q[i] & ~disp_q[i] & (qj_q[i] == '0) & (qk_q[i] == '0);
        // oldest ready entry: no ready entry allocated before it
        for (int i = 0; i < NUM_ENTRIES; i++)
            sel[i] = ready[i] & ~|(older_q[i] & ready);
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (sel[i]) begin
                fu_tag    = TAG_W'(TAG_BASE + i);
                fu_opcode = opc_q[i];
                fu_a      = vj_q[i];
                fu_b      = vk_q[i];
            end
        fu_valid = |ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            disp_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                older_q[i] <= '0;
                opc_q[i]   <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc && alloc_idx == IW'(i)) begin
                    busy_q[i]  <= 1'b1;
                    disp_q[i]  <= 1'b0;
                    opc_q[i]   <= issue_opcode;
                    vj_q[i]    <= byp_j ? cdb_data : issue_op_1;
                    qj_q[i]    <= byp_j ? '0 : issue_tag_1;
                    vk_q[i]    <= byp_k ? cdb_data : issue_op_2;
                    qk_q[i]    <= byp_k ? '0 : issue_tag_2;
                    older_q[i] <= busy_q;
                end else begin
                    if (busy_q[i] && cdb_id != '0 && qj_q[i] == cdb_id) begin
                        vj_q[i] <= cdb_data;
                        qj_q[i] <= '0;
                    end
                    if (busy_q[i] && cdb_id != '0 && qk_q[i] == cdb_id) begin
                        vk_q[i] <= cdb_data;
                        qk_q[i] <= '0;
                    end
                    if (fire && sel[i]) disp_q[i] <= 1'b1;
                    if (busy_q[i] && cdb_id == TAG_W'(TAG_BASE + i)) begin
                        busy_q[i] <= 1'b0;
                        disp_q[i] <= 1'b0;
                    end
                    if (alloc) older_q[i][alloc_idx] <= 1'b0;
                end
            end
        end
    end
`ifdef ADD_RS_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_full_cycles <= '0;
            perf_dispatches  <= '0;
        end else begin
            if (issue_valid && rs_full && perf_full_cycles != '1) perf_full_cycles <= perf_full_cycles + 32'd1;
            if (fire && perf_dispatches != '1) perf_dispatches <= perf_dispatches + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_add_rs_bank.sv
// tb_add_rs_bank: directed self-checking bench for add_rs_bank.
// Perf counter checks are included when ADD_RS_PERF_CNT_EN is defined.
module tb_add_rs_bank;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        issue_valid = 1'b0, fu_ready = 1'b0;
    logic [5:0]  issue_opcode = '0;
    logic [63:0] issue_op_1 = '0, issue_op_2 = '0, cdb_data = '0;
    logic [3:0]  issue_tag_1 = '0, issue_tag_2 = '0, cdb_id = '0;
    logic [3:0]  rs_tag, fu_tag;
    logic        rs_full, fu_valid;
    logic [5:0]  fu_opcode;
    logic [63:0] fu_a, fu_b;
    logic [2:0]  busy;
    int          n_vec = 0, n_err = 0;
`ifdef ADD_RS_PERF_CNT_EN
    logic [31:0] perf_full_cycles, perf_dispatches;
`endif
    add_rs_bank dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_op_1(issue_op_1), .issue_op_2(issue_op_2),
        .issue_tag_1(issue_tag_1), .issue_tag_2(issue_tag_2),
        .rs_tag(rs_tag), .rs_full(rs_full),
        .cdb_id(cdb_id), .cdb_data(cdb_data),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag),
        .fu_opcode(fu_opcode), .fu_a(fu_a), .fu_b(fu_b),
        .busy(busy)
`ifdef ADD_RS_PERF_CNT_EN
        ,
        .perf_full_cycles(perf_full_cycles), .perf_dispatches(perf_dispatches)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask
    task automatic issue(input logic [5:0] opc, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] ta, input logic [3:0] tb);
        issue_valid  = 1'b1;
        issue_opcode = opc;
        issue_op_1   = a;
        issue_op_2   = b;
        issue_tag_1  = ta;
        issue_tag_2  = tb;
    endtask
    initial begin
        #12;
        chk("rst_rs_tag", rs_tag, 1);
        chk("rst_rs_full", rs_full, 0);
        chk("rst_fu_valid", fu_valid, 0);
        chk("rst_fu_tag", fu_tag, 0);
        chk("rst_fu_a", fu_a, 0);
        chk("rst_fu_b", fu_b, 0);
        chk("rst_fu_opcode", fu_opcode, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc;
        // simple ready-at-issue instruction
        issue(6'h01, 64'd5, 64'd7, 4'd0, 4'd0);
        fu_ready = 1'b1;
        #1 chk("t1_rs_tag", rs_tag, 1);
        cyc;
        issue_valid = 1'b0;
        #1;
        chk("t1_fu_valid", fu_valid, 1);
        chk("t1_fu_tag", fu_tag, 1);
        chk("t1_fu_a", fu_a, 5);
        chk("t1_fu_b", fu_b, 7);
        chk("t1_fu_opcode", fu_opcode, 1);
        chk("t1_busy", busy, 3'b001);
        cyc;
        chk("t1_disp_valid", fu_valid, 0);
        chk("t1_disp_busy", busy, 3'b001);
        cdb_id = 4'd1;
        cyc;
        cdb_id = 4'd0;
        #1;
        chk("t1_free_busy", busy, 0);
        chk("t1_free_rs_tag", rs_tag, 1);
        // same-edge CDB bypass of operand 1
        issue(6'h02, 64'h99, 64'd3, 4'd6, 4'd0);
        cdb_id   = 4'd6;
        cdb_data = 64'h2A;
        #1 chk("t2_rs_tag", rs_tag, 1);
        cyc;
        issue_valid = 1'b0;
        cdb_id      = 4'd0;
        #1;
        chk("t2_fu_valid", fu_valid, 1);
        chk("t2_fu_tag", fu_tag, 1);
        chk("t2_fu_a", fu_a, 64'h2A);
        chk("t2_fu_b", fu_b, 3);
        cyc;
        chk("t2_disp_valid", fu_valid, 0);
        cdb_id = 4'd1;
        cyc;
        cdb_id = 4'd0;
        #1 chk("t2_free_busy", busy, 0);
        // fill all entries waiting on tag 4
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        fu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(6'h03, 64'd0, 64'(k + 1), 4'd4, 4'd0);
            #1 chk("t3_rs_tag", rs_tag, 64'(k + 1));
            cyc;
        end
        issue(6'h3F, 64'hEE, 64'hEE, 4'd0, 4'd0);
        #1;
        chk("t3_full", rs_full, 1);
        chk("t3_full_rs_tag", rs_tag, 0);
        chk("t3_full_busy", busy, 3'b111);
        chk("t3_full_fu_valid", fu_valid, 0);
        repeat (4) cyc;
        issue_valid = 1'b0;
        chk("t3_ignored_busy", busy, 3'b111);
        chk("t3_ignored_fu_valid", fu_valid, 0);
        cdb_id   = 4'd4;
        cdb_data = 64'd9;
        cyc;
        cdb_id   = 4'd0;
        fu_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_fu_valid", fu_valid, 1);
            chk("t3_fu_tag", fu_tag, 64'(k + 1));
            chk("t3_fu_a", fu_a, 9);
            chk("t3_fu_b", fu_b, 64'(k + 1));
            chk("t3_fu_opcode", fu_opcode, 3);
            cyc;
        end
        chk("t3_drained", fu_valid, 0);
`ifdef ADD_RS_PERF_CNT_EN
        chk("perf_full_cycles", perf_full_cycles, 4);
        chk("perf_dispatches", perf_dispatches, 3);
`endif
        for (int k = 1; k <= 3; k++) begin
            cdb_id = 4'(k);
            cyc;
        end
        cdb_id = 4'd0;
        #1 chk("t3_free_busy", busy, 0);
        // allocate entry 1 before entry 0, then check age priority and hold
        fu_ready = 1'b0;
        issue(6'h04, 64'd0, 64'd0, 4'd7, 4'd0);
        #1 chk("t4_rs_tag_a", rs_tag, 1);
        cyc;
        issue(6'h04, 64'd0, 64'h20, 4'd5, 4'd0);
        #1 chk("t4_rs_tag_b", rs_tag, 2);
        cyc;
        issue_valid = 1'b0;
        cdb_id      = 4'd1;
        cyc;
        cdb_id = 4'd0;
        #1;
        chk("t4_busy_after_free", busy, 3'b010);
        chk("t4_rs_tag_reuse", rs_tag, 1);
        issue(6'h05, 64'h30, 64'h31, 4'd0, 4'd0);
        cyc;
        issue_valid = 1'b0;
        #1 chk("t4_young_only", fu_tag, 1);
        cdb_id   = 4'd5;
        cdb_data = 64'h55;
        cyc;
        cdb_id = 4'd0;
        #1;
        chk("t4_old_takes_prio", fu_tag, 2);
        chk("t4_old_fu_a", fu_a, 64'h55);
        chk("t4_old_fu_b", fu_b, 64'h20);
        chk("t4_old_opcode", fu_opcode, 4);
        cyc;
        chk("t4_hold_tag", fu_tag, 2);
        chk("t4_hold_valid", fu_valid, 1);
        fu_ready = 1'b1;
        cyc;
        chk("t4_next_tag", fu_tag, 1);
        chk("t4_next_fu_a", fu_a, 64'h30);
        cyc;
        chk("t4_drained", fu_valid, 0);
        chk("t4_busy", busy, 3'b011);
        // asynchronous reset with a pending dispatch
        cdb_id = 4'd1;
        cyc;
        cdb_id   = 4'd0;
        fu_ready = 1'b0;
        issue(6'h06, 64'd1, 64'd2, 4'd0, 4'd0);
        cyc;
        issue_valid = 1'b0;
        #1;
        chk("t5_pre_valid", fu_valid, 1);
        chk("t5_pre_busy", busy, 3'b011);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_fu_valid", fu_valid, 0);
        chk("t5_fu_tag", fu_tag, 0);
        chk("t5_rs_tag", rs_tag, 1);
        rst_n = 1'b1;
        cyc;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
